// File: rtl/out_fifo_drain_arbiter.sv
// Purpose: round-robin drain of N_CH OUT FIFOs into one registered, channel-tagged byte stream.
// Latency: 1 cycle from arbitration to first pop, 1 cycle from pop to app_out_valid_o; one byte/cycle in a burst.
// Backpressure: valid/ready; while app_out_ready_i=0 the output byte holds and the granted FIFO is not popped.
// Ports:
//   clk_i, rst_i             clock (shared with the FIFOs), synchronous active-high reset
//   ch_en_i, ch_empty_i      per-channel enable and FIFO empty flag
//   ch_data_i, ch_valid_i    per-channel FIFO byte (channel k at [8k+:8]) and byte valid
//   ch_ready_o               pop strobe to the granted FIFO, one-hot or zero
//   app_out_data_o/_ch_o     merged byte and its source channel
//   app_out_valid_o/_ready_i merged stream handshake
//   grant_o, busy_o          current or last granted channel, and drain in progress (debug)
module out_fifo_drain_arbiter #(
  parameter int N_CH      = 4,
  parameter int BURST_LEN = 8,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_CH-1:0]      ch_en_i,
  input  logic [N_CH-1:0]      ch_empty_i,
  input  logic [8*N_CH-1:0]    ch_data_i,
  input  logic [N_CH-1:0]      ch_valid_i,
  output logic [N_CH-1:0]      ch_ready_o,
  output logic [7:0]           app_out_data_o,
  output logic [CH_W-1:0]      app_out_ch_o,
  output logic                 app_out_valid_o,
  input  logic                 app_out_ready_i,
  output logic [CH_W-1:0]      grant_o,
  output logic                 busy_o
);

  localparam int                BCNT_W   = $clog2(BURST_LEN + 1);
  localparam logic [BCNT_W-1:0] CNT_LAST = BCNT_W'(BURST_LEN - 1);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(N_CH - 1);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  // grant_q doubles as last_grant: after a release it still holds the channel
  // just served, which is exactly where the next round-robin search starts.
  logic [CH_W-1:0]    grant_q, grant_d;
  logic [BCNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_data_q, out_data_d;
  logic [CH_W-1:0]    out_ch_q, out_ch_d;

  logic [N_CH-1:0]    cand;
  logic [CH_W-1:0]    scan_idx;
  logic [CH_W-1:0]    arb_pick;
  logic               arb_found;
  logic               pop_rdy;
  logic               accept;
  logic               rel_ch;
  logic [7:0]         grant_data;

  assign cand       = ch_en_i & ~ch_empty_i;
  assign grant_data = ch_data_i[{grant_q, 3'b000} +: 8];

  // Round-robin search starting one past the last grant; the last grant
  // itself is the final position checked, so a lone requester is re-granted.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = grant_q;
    scan_idx  = grant_q;
    for (int off = 1; off <= N_CH; off++) begin
      scan_idx = CH_W'((int'(grant_q) + off) % N_CH);
      if (!arb_found && cand[scan_idx]) begin
        arb_found = 1'b1;
        arb_pick  = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    ch_ready_o  = '0;
    pop_rdy     = 1'b0;
    accept      = 1'b0;
    rel_ch      = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (arb_found) begin
          state_d     = ST_DRAIN;
          grant_d     = arb_pick;
          burst_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        // Pop only when the output register is free or being emptied now.
        pop_rdy = ~out_valid_q | app_out_ready_i;
        // Gated by reset so a FIFO is never popped into a register that is
        // being cleared; unpopped bytes survive a reset.
        ch_ready_o[grant_q] = pop_rdy & ~rst_i;
        accept = ch_valid_i[grant_q] & pop_rdy;
        if (accept) begin
          burst_cnt_d = burst_cnt_q + BCNT_W'(1);
        end
        // A valid gap on a non-empty FIFO is pacing, not a reason to release.
        rel_ch = (accept && (burst_cnt_q == CNT_LAST)) ||
                 (!accept && (ch_empty_i[grant_q] || !ch_en_i[grant_q]));
        if (rel_ch) begin
          state_d     = ST_ARB;
          burst_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // Output register: a fresh byte has priority over draining the old one,
  // which gives one byte per cycle when pop and consume coincide.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_ch_d    = grant_q;
    end else if (app_out_ready_i && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_ARB;
      grant_q     <= CH_LAST;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign app_out_data_o  = out_data_q;
  assign app_out_ch_o    = out_ch_q;
  assign app_out_valid_o = out_valid_q;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_out_fifo_drain_arbiter.sv
// Purpose: bench for out_fifo_drain_arbiter with per-channel FIFO models and an output scoreboard.
// Latency: inputs change 1ns after posedge, outputs sampled on negedge or 2ns after posedge.
// Backpressure: FIFO models pop only on ch_ready_o & ch_valid_i; app_out_ready_i is driven per test.
module tb_out_fifo_drain_arbiter;
  localparam int N_CH      = 4;
  localparam int BURST_LEN = 8;
  localparam int CH_W      = 2;

  logic                 clk_i           = 1'b0;
  logic                 rst_i           = 1'b1;
  logic [N_CH-1:0]      ch_en_i         = '1;
  logic [N_CH-1:0]      ch_empty_i      = '1;
  logic [8*N_CH-1:0]    ch_data_i       = '0;
  logic [N_CH-1:0]      ch_valid_i      = '0;
  logic [N_CH-1:0]      ch_ready_o;
  logic [7:0]           app_out_data_o;
  logic [CH_W-1:0]      app_out_ch_o;
  logic                 app_out_valid_o;
  logic                 app_out_ready_i = 1'b1;
  logic [CH_W-1:0]      grant_o;
  logic                 busy_o;

  logic [7:0]           fq [N_CH][$];
  logic [N_CH-1:0]      gap      = '0;
  logic [N_CH-1:0]      pop_next = '0;
  logic [9:0]           exp_q [$];
  logic [9:0]           mon_exp;
  int                   total = 0;
  int                   bad   = 0;

  out_fifo_drain_arbiter #(
    .N_CH      (N_CH),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .ch_en_i         (ch_en_i),
    .ch_empty_i      (ch_empty_i),
    .ch_data_i       (ch_data_i),
    .ch_valid_i      (ch_valid_i),
    .ch_ready_o      (ch_ready_o),
    .app_out_data_o  (app_out_data_o),
    .app_out_ch_o    (app_out_ch_o),
    .app_out_valid_o (app_out_valid_o),
    .app_out_ready_i (app_out_ready_i),
    .grant_o         (grant_o),
    .busy_o          (busy_o)
  );

  initial forever #5 clk_i = ~clk_i;

  // FIFO models: pop what the DUT accepted at this edge, then present the new head.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      for (int k = 0; k < N_CH; k++) begin
        if (pop_next[k] && fq[k].size() > 0) fq[k].delete(0);
        ch_empty_i[k]       = (fq[k].size() == 0);
        ch_valid_i[k]       = (fq[k].size() != 0) && !gap[k];
        ch_data_i[8*k +: 8] = (fq[k].size() != 0) ? fq[k][0] : 8'h00;
      end
    end
  end

  // Scoreboard: every byte consumed at the coming edge must match the queue head.
  always @(negedge clk_i) begin
    pop_next = ch_ready_o & ch_valid_i;
    if (!rst_i && app_out_valid_o === 1'b1 && app_out_ready_i === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_byte: got unexpected ch=%0d data=%02h, required no output", app_out_ch_o, app_out_data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({app_out_ch_o, app_out_data_o} !== mon_exp) begin
          bad++;
          $display("FAIL out_byte: got ch=%0d data=%02h, required ch=%0d data=%02h",
                   app_out_ch_o, app_out_data_o, mon_exp[9:8], mon_exp[7:0]);
        end
      end
    end
    if (ch_ready_o !== '0) begin
      total++;
      if ($countones(ch_ready_o) != 1) begin
        bad++;
        $display("FAIL ready_onehot: got %b, required one-hot", ch_ready_o);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic push_fifo(input int k, input logic [7:0] v);
    fq[k].push_back(v);
  endtask

  task automatic expect_byte(input int k, input logic [7:0] v);
    exp_q.push_back({CH_W'(k), v});
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (exp_q.size() == 0 && busy_o === 1'b0 && app_out_valid_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (app_out_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(2);
    total++; if (app_out_valid_o !== 1'b0)  begin bad++; $display("FAIL reset_valid: got %b required 0", app_out_valid_o); end
    total++; if (app_out_data_o !== 8'h00)  begin bad++; $display("FAIL reset_data: got %02h required 00", app_out_data_o); end
    total++; if (app_out_ch_o !== 2'd0)     begin bad++; $display("FAIL reset_ch: got %0d required 0", app_out_ch_o); end
    total++; if (ch_ready_o !== 4'b0000)    begin bad++; $display("FAIL reset_ready: got %b required 0000", ch_ready_o); end
    total++; if (busy_o !== 1'b0)           begin bad++; $display("FAIL reset_busy: got %b required 0", busy_o); end
    total++; if (grant_o !== 2'd3)          begin bad++; $display("FAIL reset_grant: got %0d required 3", grant_o); end
    rst_i = 1'b0;
    tick(1);
  endtask

  task automatic test_round_robin();
    bit ok;
    for (int i = 0; i < 10; i++) begin
      push_fifo(0, 8'(i));
      push_fifo(2, 8'(8'h80 + i));
    end
    for (int i = 0; i < 8; i++)  expect_byte(0, 8'(i));
    for (int i = 0; i < 8; i++)  expect_byte(2, 8'(8'h80 + i));
    for (int i = 8; i < 10; i++) expect_byte(0, 8'(i));
    for (int i = 8; i < 10; i++) expect_byte(2, 8'(8'h80 + i));
    wait_idle(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL rr_drain: got %0d bytes left, required 0", exp_q.size()); end
    total++; if (grant_o !== 2'd2) begin bad++; $display("FAIL rr_last_grant: got %0d required 2", grant_o); end
  endtask

  task automatic test_single();
    bit ok;
    push_fifo(0, 8'h11); push_fifo(0, 8'h22); push_fifo(0, 8'h33);
    expect_byte(0, 8'h11); expect_byte(0, 8'h22); expect_byte(0, 8'h33);
    tick(2);
    total++; if ({busy_o, app_out_valid_o, grant_o} !== {1'b1, 1'b0, 2'd0}) begin
      bad++; $display("FAIL t1_grant: got busy=%b valid=%b grant=%0d required 1 0 0", busy_o, app_out_valid_o, grant_o);
    end
    tick(1);
    total++; if ({app_out_valid_o, app_out_ch_o, app_out_data_o} !== {1'b1, 2'd0, 8'h11}) begin
      bad++; $display("FAIL t1_latency: got valid=%b ch=%0d data=%02h required 1 0 11", app_out_valid_o, app_out_ch_o, app_out_data_o);
    end
    wait_idle(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL t1_drain: got %0d bytes left, required 0", exp_q.size()); end
    total++; if (ch_ready_o !== 4'b0000) begin bad++; $display("FAIL t1_ready_idle: got %b required 0000", ch_ready_o); end
  endtask

  task automatic test_pacing_gap();
    bit ok;
    for (int i = 0; i < 4; i++) begin
      push_fifo(2, 8'(8'hA0 + i));
      expect_byte(2, 8'(8'hA0 + i));
    end
    push_fifo(0, 8'h55);
    expect_byte(0, 8'h55);
    wait_valid(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL gap_first: got no output, required a byte"); end
    gap[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      total++; if ({busy_o, grant_o} !== {1'b1, 2'd2}) begin
        bad++; $display("FAIL gap_hold: got busy=%b grant=%0d required 1 2", busy_o, grant_o);
      end
    end
    gap[2] = 1'b0;
    wait_idle(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL gap_drain: got %0d bytes left, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    app_out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_fifo(0, 8'(8'hD0 + i));
      expect_byte(0, 8'(8'hD0 + i));
    end
    wait_valid(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_first: got no output, required a byte"); end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      total++; if ({app_out_valid_o, app_out_ch_o, app_out_data_o, ch_ready_o} !== {1'b1, 2'd0, 8'hD0, 4'b0000}) begin
        bad++; $display("FAIL bp_hold: got valid=%b ch=%0d data=%02h ready=%b required 1 0 d0 0000",
                        app_out_valid_o, app_out_ch_o, app_out_data_o, ch_ready_o);
      end
    end
    app_out_ready_i = 1'b1;
    #1;
    total++; if (ch_ready_o !== 4'b0001) begin bad++; $display("FAIL bp_release_ready: got %b required 0001", ch_ready_o); end
    tick(1);
    total++; if (fq[0].size() != 2) begin bad++; $display("FAIL bp_same_cycle_pop: got %0d left in fifo0, required 2", fq[0].size()); end
    wait_idle(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_drain: got %0d bytes left, required 0", exp_q.size()); end
  endtask

  task automatic test_enable();
    bit ok;
    ch_en_i = 4'b1101;
    for (int i = 0; i < 3; i++) push_fifo(1, 8'(8'hC0 + i));
    push_fifo(0, 8'h60); push_fifo(0, 8'h61);
    expect_byte(0, 8'h60); expect_byte(0, 8'h61);
    wait_idle(50, ok);
    tick(5);
    total++; if (!ok) begin bad++; $display("FAIL en_drain: got %0d bytes left, required 0", exp_q.size()); end
    total++; if (fq[1].size() != 3) begin bad++; $display("FAIL en_skip: got %0d left in fifo1, required 3", fq[1].size()); end
    total++; if ({busy_o, grant_o} !== {1'b0, 2'd0}) begin bad++; $display("FAIL en_idle: got busy=%b grant=%0d required 0 0", busy_o, grant_o); end
    push_fifo(2, 8'hE0); push_fifo(3, 8'hF0);
    ch_en_i = 4'b1111;
    for (int i = 0; i < 3; i++) expect_byte(1, 8'(8'hC0 + i));
    expect_byte(2, 8'hE0); expect_byte(3, 8'hF0);
    wait_idle(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL en_reenable: got %0d bytes left, required 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    push_fifo(3, 8'h30); push_fifo(3, 8'h31);
    push_fifo(0, 8'h01); push_fifo(0, 8'h02);
    expect_byte(0, 8'h01); expect_byte(0, 8'h02);
    expect_byte(3, 8'h30); expect_byte(3, 8'h31);
    tick(2);
    total++; if ({busy_o, grant_o} !== {1'b1, 2'd0}) begin bad++; $display("FAIL wrap_grant: got busy=%b grant=%0d required 1 0", busy_o, grant_o); end
    wait_idle(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_drain: got %0d bytes left, required 0", exp_q.size()); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    app_out_ready_i = 1'b0;
    push_fifo(0, 8'h71); push_fifo(0, 8'h72); push_fifo(0, 8'h73);
    wait_valid(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL mr_first: got no output, required a byte"); end
    rst_i = 1'b1;
    push_fifo(3, 8'h3A); push_fifo(3, 8'h3B);
    tick(1);
    total++; if ({app_out_valid_o, app_out_ch_o, app_out_data_o, ch_ready_o, busy_o, grant_o} !==
                 {1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 2'd3}) begin
      bad++; $display("FAIL mr_reset_state: got valid=%b ch=%0d data=%02h ready=%b busy=%b grant=%0d required 0 0 00 0000 0 3",
                      app_out_valid_o, app_out_ch_o, app_out_data_o, ch_ready_o, busy_o, grant_o);
    end
    rst_i = 1'b0;
    app_out_ready_i = 1'b1;
    expect_byte(0, 8'h72); expect_byte(0, 8'h73);
    expect_byte(3, 8'h3A); expect_byte(3, 8'h3B);
    wait_idle(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL mr_drain: got %0d bytes left, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_pacing_gap();
    test_backpressure();
    test_enable();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
